// File: rtl/pipeline_stall_controller_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipeline_stall_controller_if: hazard/memory handshake inputs and per-stage |
// | enable/flush outputs; perf counters present with STALL_PERF_CNT_EN.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface pipeline_stall_controller_if;
    logic        load_use_hazard;
    logic        branch_taken;
    logic        imem_ready;
    logic        dmem_req;
    logic        dmem_ready;
    logic        pc_en;
    logic        if_id_en;
    logic        if_id_flush;
    logic        id_ex_bubble;
    logic        ex_mem_en;
    logic        mem_wb_en;
    logic        mem_timeout;
`ifdef STALL_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;
`endif

    modport master (
        output load_use_hazard, branch_taken, imem_ready, dmem_req, dmem_ready,
        input  pc_en, if_id_en, if_id_flush, id_ex_bubble, ex_mem_en, mem_wb_en,
        input  mem_timeout
`ifdef STALL_PERF_CNT_EN
        , input stall_cycles, flush_count
`endif
    );

    modport slave (
        input  load_use_hazard, branch_taken, imem_ready, dmem_req, dmem_ready,
        output pc_en, if_id_en, if_id_flush, id_ex_bubble, ex_mem_en, mem_wb_en,
        output mem_timeout
`ifdef STALL_PERF_CNT_EN
        , output stall_cycles, flush_count
`endif
    );
endinterface
`default_nettype wire

// File: rtl/pipeline_stall_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipeline_stall_controller: stall/flush sequencer for the 5-stage pipeline. |
// | Optional macro STALL_PERF_CNT_EN adds stall/flush performance counters.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pipeline_stall_controller #(
    parameter int MAX_WAIT = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    pipeline_stall_controller_if.slave    bus
);
    localparam logic [7:0] c_MAX_WAIT = MAX_WAIT[7:0];

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        DMEM_WAIT = 2'd1,
        IMEM_WAIT = 2'd2
    } state_t;

    state_t     r_state;
    logic [7:0] r_wait_cnt;
    logic       r_redirect_pending;
    logic       r_mem_timeout;

    state_t     w_next;
    logic       w_freeze;
    logic       w_entry;
    logic       w_in_wait;
    logic [7:0] w_cnt_inc;
    logic       w_redirect_next;
    logic       w_pc_en;
    logic       w_if_id_en;
    logic       w_if_id_flush;
    logic       w_id_ex_bubble;
    logic       w_ex_mem_en;
    logic       w_mem_wb_en;

    // A pending data access keeps the freeze even if the MEM stage drops dmem_req.
    assign w_freeze = (bus.dmem_req & ~bus.dmem_ready) |
                      ((r_state == DMEM_WAIT) & ~bus.dmem_ready);

    always_comb begin
        w_pc_en         = 1'b1;
        w_if_id_en      = 1'b1;
        w_if_id_flush   = 1'b0;
        w_id_ex_bubble  = 1'b0;
        w_ex_mem_en     = 1'b1;
        w_mem_wb_en     = 1'b1;
        w_next          = bus.imem_ready ? RUN : IMEM_WAIT;
        w_redirect_next = r_redirect_pending;
        if (w_freeze) begin
            w_pc_en     = 1'b0;
            w_if_id_en  = 1'b0;
            w_ex_mem_en = 1'b0;
            w_mem_wb_en = 1'b0;
            w_next      = DMEM_WAIT;
        end else if (bus.load_use_hazard) begin
            w_pc_en        = 1'b0;
            w_if_id_en     = 1'b0;
            w_id_ex_bubble = 1'b1;
        end else if (bus.branch_taken) begin
            w_if_id_flush   = 1'b1;
            w_redirect_next = ~bus.imem_ready;
        end else if (!bus.imem_ready) begin
            w_pc_en       = 1'b0;
            w_if_id_flush = 1'b1;
        end else begin
            // Fetch returned after a redirect: the word is from the wrong path.
            w_if_id_flush   = r_redirect_pending;
            w_redirect_next = 1'b0;
        end
        if (!rst_n) begin
            w_pc_en        = 1'b0;
            w_if_id_en     = 1'b0;
            w_if_id_flush  = 1'b1;
            w_id_ex_bubble = 1'b1;
            w_ex_mem_en    = 1'b0;
            w_mem_wb_en    = 1'b0;
        end
    end

    assign w_in_wait = (r_state != RUN);
    assign w_entry   = (w_next != RUN) && (w_next != r_state);
    assign w_cnt_inc = (r_wait_cnt == c_MAX_WAIT) ? r_wait_cnt : r_wait_cnt + 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state            <= RUN;
            r_wait_cnt         <= 8'd0;
            r_redirect_pending <= 1'b0;
            r_mem_timeout      <= 1'b0;
        end else begin
            r_state            <= w_next;
            r_redirect_pending <= w_redirect_next;
            if (w_entry) begin
                r_wait_cnt <= 8'd0;
            end else if (w_in_wait) begin
                r_wait_cnt <= w_cnt_inc;
                if (w_cnt_inc == c_MAX_WAIT) begin
                    r_mem_timeout <= 1'b1;
                end
            end
        end
    end

    assign bus.pc_en        = w_pc_en;
    assign bus.if_id_en     = w_if_id_en;
    assign bus.if_id_flush  = w_if_id_flush;
    assign bus.id_ex_bubble = w_id_ex_bubble;
    assign bus.ex_mem_en    = w_ex_mem_en;
    assign bus.mem_wb_en    = w_mem_wb_en;
    assign bus.mem_timeout  = r_mem_timeout;

`ifdef STALL_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= 32'd0;
            r_flush_count  <= 32'd0;
        end else begin
            if (!w_pc_en) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (w_if_id_flush) begin
                r_flush_count <= r_flush_count + 32'd1;
            end
        end
    end

    assign bus.stall_cycles = r_stall_cycles;
    assign bus.flush_count  = r_flush_count;
`endif
endmodule
`default_nettype wire

// File: tb/tb_pipeline_stall_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pipeline_stall_controller: directed bench for pipeline_stall_controller |
// | (MAX_WAIT=4); perf counter checks built with STALL_PERF_CNT_EN.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_pipeline_stall_controller;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    pipeline_stall_controller_if bus ();

    pipeline_stall_controller #(.MAX_WAIT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // {pc_en, if_id_en, if_id_flush, id_ex_bubble, ex_mem_en, mem_wb_en}
    logic [5:0] w_o;
    assign w_o = {bus.pc_en, bus.if_id_en, bus.if_id_flush,
                  bus.id_ex_bubble, bus.ex_mem_en, bus.mem_wb_en};

    localparam logic [5:0] c_RESET  = 6'b001100;
    localparam logic [5:0] c_RUN    = 6'b110011;
    localparam logic [5:0] c_FREEZE = 6'b000000;
    localparam logic [5:0] c_LU     = 6'b000111;
    localparam logic [5:0] c_BRANCH = 6'b111011;
    localparam logic [5:0] c_FETCHW = 6'b011011;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic lu, input logic br, input logic im,
                         input logic dq, input logic dy);
        bus.load_use_hazard = lu;
        bus.branch_taken    = br;
        bus.imem_ready      = im;
        bus.dmem_req        = dq;
        bus.dmem_ready      = dy;
    endtask

    task automatic test_reset;
        #1;
        n_cmp++;
        if (w_o !== c_RESET || bus.mem_timeout !== 1'b0) begin
            n_err++;
            $display("FAIL reset_values got %b/%b want %b/0", w_o, bus.mem_timeout, c_RESET);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (w_o !== c_RUN) begin
            n_err++;
            $display("FAIL reset_release got %b want %b", w_o, c_RUN);
        end
    endtask

    task automatic test_load_use;
        @(negedge clk); drive(1, 0, 1, 0, 0); #1;
        n_cmp++;
        if (w_o !== c_LU) begin
            n_err++;
            $display("FAIL load_use got %b want %b", w_o, c_LU);
        end
        @(negedge clk); drive(1, 1, 1, 0, 0); #1;
        n_cmp++;
        if (w_o !== c_LU) begin
            n_err++;
            $display("FAIL load_use_over_branch got %b want %b", w_o, c_LU);
        end
        @(negedge clk); drive(0, 0, 1, 0, 0); #1;
        n_cmp++;
        if (w_o !== c_RUN) begin
            n_err++;
            $display("FAIL load_use_release got %b want %b", w_o, c_RUN);
        end
    endtask

    task automatic test_dmem_wait;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); drive(0, 1, 1, 1, 0); #1;
            n_cmp++;
            if (w_o !== c_FREEZE) begin
                n_err++;
                $display("FAIL dmem_freeze[%0d] got %b want %b", i, w_o, c_FREEZE);
            end
        end
        @(negedge clk); drive(0, 0, 1, 1, 1); #1;
        n_cmp++;
        if (w_o !== c_RUN) begin
            n_err++;
            $display("FAIL dmem_release got %b want %b", w_o, c_RUN);
        end
        @(negedge clk); drive(0, 0, 1, 0, 1); #1;
        n_cmp++;
        if (w_o !== c_RUN || bus.mem_timeout !== 1'b0) begin
            n_err++;
            $display("FAIL dmem_ready_no_req got %b/%b want %b/0", w_o, bus.mem_timeout, c_RUN);
        end
    endtask

    task automatic test_branch_redirect;
        logic [5:0] exp_seq [4];
        logic       im_seq  [4];
        exp_seq = '{c_BRANCH, c_FETCHW, c_BRANCH, c_RUN};
        im_seq  = '{1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); drive(0, (i == 0), im_seq[i], 0, 0); #1;
            n_cmp++;
            if (w_o !== exp_seq[i]) begin
                n_err++;
                $display("FAIL branch_redirect[%0d] got %b want %b", i, w_o, exp_seq[i]);
            end
        end
        @(negedge clk); drive(0, 0, 0, 0, 0); #1;
        n_cmp++;
        if (w_o !== c_FETCHW) begin
            n_err++;
            $display("FAIL fetch_wait got %b want %b", w_o, c_FETCHW);
        end
        @(negedge clk); drive(0, 0, 1, 0, 0); #1;
        n_cmp++;
        if (w_o !== c_RUN) begin
            n_err++;
            $display("FAIL fetch_return_no_redirect got %b want %b", w_o, c_RUN);
        end
    endtask

    task automatic test_redirect_across_dmem;
        logic [5:0] exp_seq [4];
        exp_seq = '{c_BRANCH, c_FREEZE, c_BRANCH, c_RUN};
        @(negedge clk); drive(0, 1, 0, 0, 0); #1;
        n_cmp++;
        if (w_o !== exp_seq[0]) begin
            n_err++;
            $display("FAIL redirect_dmem[0] got %b want %b", w_o, exp_seq[0]);
        end
        @(negedge clk); drive(0, 0, 0, 1, 0); #1;
        n_cmp++;
        if (w_o !== exp_seq[1]) begin
            n_err++;
            $display("FAIL redirect_dmem[1] got %b want %b", w_o, exp_seq[1]);
        end
        @(negedge clk); drive(0, 0, 1, 1, 1); #1;
        n_cmp++;
        if (w_o !== exp_seq[2]) begin
            n_err++;
            $display("FAIL redirect_dmem[2] got %b want %b", w_o, exp_seq[2]);
        end
        @(negedge clk); drive(0, 0, 1, 0, 0); #1;
        n_cmp++;
        if (w_o !== exp_seq[3]) begin
            n_err++;
            $display("FAIL redirect_dmem[3] got %b want %b", w_o, exp_seq[3]);
        end
    endtask

    task automatic test_timeout;
        logic exp_to;
        // Entry cycle plus four cycles in DMEM_WAIT; the flag shows from the sixth.
        for (int i = 0; i < 6; i++) begin
            exp_to = (i >= 5);
            @(negedge clk); drive(0, 0, 1, 1, 0); #1;
            n_cmp++;
            if (w_o !== c_FREEZE || bus.mem_timeout !== exp_to) begin
                n_err++;
                $display("FAIL timeout_wait[%0d] got %b/%b want %b/%b",
                         i, w_o, bus.mem_timeout, c_FREEZE, exp_to);
            end
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); drive(0, 0, 1, (i == 0), 1); #1;
            n_cmp++;
            if (w_o !== c_RUN || bus.mem_timeout !== 1'b1) begin
                n_err++;
                $display("FAIL timeout_sticky[%0d] got %b/%b want %b/1",
                         i, w_o, bus.mem_timeout, c_RUN);
            end
        end
    endtask

    task automatic test_reset_mid_wait;
        @(negedge clk); drive(0, 0, 1, 1, 0);
        @(negedge clk); #1;
        n_cmp++;
        if (w_o !== c_FREEZE) begin
            n_err++;
            $display("FAIL pre_reset_freeze got %b want %b", w_o, c_FREEZE);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (w_o !== c_RESET || bus.mem_timeout !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset got %b/%b want %b/0", w_o, bus.mem_timeout, c_RESET);
        end
        drive(0, 0, 1, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (w_o !== c_RUN) begin
            n_err++;
            $display("FAIL reset_abort_wait got %b want %b", w_o, c_RUN);
        end
        @(negedge clk); drive(0, 0, 1, 0, 0); #1;
        n_cmp++;
        if (w_o !== c_RUN || bus.mem_timeout !== 1'b0) begin
            n_err++;
            $display("FAIL run_after_reset got %b/%b want %b/0", w_o, bus.mem_timeout, c_RUN);
        end
    endtask

`ifdef STALL_PERF_CNT_EN
    task automatic test_perf_counters;
        @(negedge clk); drive(1, 0, 1, 0, 0);
        @(negedge clk); drive(1, 0, 1, 0, 0);
        @(negedge clk); drive(0, 1, 1, 0, 0);
        @(negedge clk); drive(0, 0, 1, 0, 0);
        @(negedge clk); #1;
        n_cmp++;
        if (bus.stall_cycles !== 32'd2 || bus.flush_count !== 32'd1) begin
            n_err++;
            $display("FAIL perf_counters got %0d/%0d want 2/1", bus.stall_cycles, bus.flush_count);
        end
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        drive(0, 0, 1, 0, 0);
        test_reset();
        test_load_use();
        test_dmem_wait();
        test_branch_redirect();
        test_redirect_across_dmem();
        test_timeout();
        test_reset_mid_wait();
`ifdef STALL_PERF_CNT_EN
        test_perf_counters();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
